// File: rtl/eth_tx_sched.sv
// eth_tx_sched: frame-level round-robin scheduler feeding one byte-wide TX
// framer from S_COUNT AXI-stream sources, with 802.3x PAUSE hold-off.
// Grants are only chosen between frames; a pause only delays the next grant.
module eth_tx_sched #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,

    input  logic                          clk_enable,
    input  logic                          mii_select,

    input  logic                          cfg_pause_enable,
    input  logic                          rx_pause_valid,
    input  logic [15:0]                   rx_pause_quanta,

    output logic                          grant_valid,
    output logic [CL_S_COUNT-1:0]         grant_index,
    output logic                          paused
);

    localparam int PAUSE_W = 22;
    localparam int IDX_W   = CL_S_COUNT + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [CL_S_COUNT-1:0] grant_index_reg, grant_index_next;
    logic [CL_S_COUNT-1:0] last_grant_reg, last_grant_next;
    logic [PAUSE_W-1:0]    pause_cnt_reg, pause_cnt_next;
    logic                  mii_phase_reg, mii_phase_next;
    logic                  paused_reg;

    logic                  byte_tick;
    logic                  rr_found;
    logic [CL_S_COUNT-1:0] rr_index;
    logic                  active;

    // Per-port views of the flattened source buses
    logic [DATA_WIDTH-1:0] port_tdata [S_COUNT];
    logic [USER_WIDTH-1:0] port_tuser [S_COUNT];

    assign active = (state_reg == ST_ACTIVE);

    generate
        for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
            assign port_tdata[gi]    = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign port_tuser[gi]    = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
            // Only the granted source sees the framer's ready
            assign s_axis_tready[gi] = active && m_axis_tready &&
                                       (grant_index_reg == CL_S_COUNT'(gi));
        end
    endgenerate

    // The output mux is purely combinational from the current grant
    assign m_axis_tdata  = port_tdata[grant_index_reg];
    assign m_axis_tuser  = port_tuser[grant_index_reg];
    assign m_axis_tlast  = s_axis_tlast[grant_index_reg];
    assign m_axis_tvalid = active && s_axis_tvalid[grant_index_reg];

    assign grant_valid = active;
    assign grant_index = grant_index_reg;
    assign paused      = paused_reg;

    // In MII mode a byte takes two enabled cycles, so only every other one ticks
    assign byte_tick = clk_enable && (!mii_select || mii_phase_reg);

    // Round-robin search starting just after the last port served
    always_comb begin : rr_search
        logic [IDX_W-1:0] idx;
        rr_found = 1'b0;
        rr_index = '0;
        idx      = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            idx = {1'b0, last_grant_reg} + IDX_W'(k);
            if (idx >= IDX_W'(S_COUNT)) begin
                idx = idx - IDX_W'(S_COUNT);
            end
            if (!rr_found && s_axis_tvalid[idx[CL_S_COUNT-1:0]]) begin
                rr_found = 1'b1;
                rr_index = idx[CL_S_COUNT-1:0];
            end
        end
    end

    // Pause counter: a new request replaces the count, byte ticks drain it
    always_comb begin
        pause_cnt_next = pause_cnt_reg;
        if (!cfg_pause_enable) begin
            pause_cnt_next = '0;
        end else if (rx_pause_valid) begin
            pause_cnt_next = {rx_pause_quanta, 6'd0};
        end else if (byte_tick && (pause_cnt_reg != '0)) begin
            pause_cnt_next = pause_cnt_reg - 1'b1;
        end
    end

    // MII byte phase toggles on enabled cycles and is parked at 0 in GMII mode
    always_comb begin
        mii_phase_next = mii_phase_reg;
        if (!mii_select) begin
            mii_phase_next = 1'b0;
        end else if (clk_enable) begin
            mii_phase_next = !mii_phase_reg;
        end
    end

    // Grant FSM: pick a port only between frames and only when not paused,
    // looking at both the current and the next pause count so a strobe
    // arriving alongside a request already blocks that grant
    always_comb begin
        state_next       = state_reg;
        grant_index_next = grant_index_reg;
        last_grant_next  = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rr_found && (pause_cnt_reg == '0) && (pause_cnt_next == '0)) begin
                    state_next       = ST_ACTIVE;
                    grant_index_next = rr_index;
                end
            end
            ST_ACTIVE: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_next      = ST_IDLE;
                    last_grant_next = grant_index_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant starts at the top port so port 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_index_reg <= '0;
            last_grant_reg  <= CL_S_COUNT'(S_COUNT - 1);
            pause_cnt_reg   <= '0;
            mii_phase_reg   <= 1'b0;
            paused_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_index_reg <= grant_index_next;
            last_grant_reg  <= last_grant_next;
            pause_cnt_reg   <= pause_cnt_next;
            mii_phase_reg   <= mii_phase_next;
            paused_reg      <= (pause_cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed testbench for eth_tx_sched: a bench-side frame generator per port,
// a frame-order scoreboard, and per-scenario tasks with hand-derived timing.
module tb_eth_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tuser;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic        clk_enable;
    logic        mii_select;
    logic        cfg_pause_enable;
    logic        rx_pause_valid;
    logic [15:0] rx_pause_quanta;
    logic        grant_valid;
    logic [1:0]  grant_index;
    logic        paused;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int src_left [4];
    int src_beat [4];
    int frame_len;
    int exp_order [$];
    bit mid_frame;
    bit have_prev;
    bit gap_check;
    int cur_port, mon_beat, frames_done;
    int prev_tlast_cyc, start_cyc, first_start;
    bit gv_s, paused_s;
    logic [3:0] fire;

    eth_tx_sched #(
        .S_COUNT(4), .DATA_WIDTH(8), .USER_WIDTH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .clk_enable(clk_enable), .mii_select(mii_select),
        .cfg_pause_enable(cfg_pause_enable), .rx_pause_valid(rx_pause_valid),
        .rx_pause_quanta(rx_pause_quanta),
        .grant_valid(grant_valid), .grant_index(grant_index), .paused(paused)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required simulation to finish earlier");
        $fatal(1, "watchdog");
    end

    // Source byte = port*64 + beat index, tuser = beat parity
    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]       = (src_left[i] > 0);
            s_tdata[i*8 +: 8] = 8'(i*64 + src_beat[i]);
            s_tlast[i]        = (src_beat[i] == frame_len - 1);
            s_tuser[i]        = src_beat[i][0];
        end
    endtask

    // One clock: sample at negedge, score, then advance sources after posedge
    task automatic cycle();
        logic [3:0] exp_rdy;
        int exp_port;
        cyc++;
        @(negedge clk);
        gv_s     = grant_valid;
        paused_s = paused;
        fire     = s_tvalid & s_tready;
        exp_port = mid_frame ? cur_port : ((exp_order.size() > 0) ? exp_order[0] : 0);
        exp_rdy  = (grant_valid && m_tready) ? 4'(1 << exp_port) : 4'b0;
        checks++;
        if (s_tready !== exp_rdy) begin
            errors++;
            $display("FAIL tready cyc %0d: got %b, required %b", cyc, s_tready, exp_rdy);
        end
        if (grant_valid) begin
            checks++;
            if (grant_index !== 2'(exp_port)) begin
                errors++;
                $display("FAIL grant_index cyc %0d: got %0d, required %0d", cyc, grant_index, exp_port);
            end
        end
        if (m_tvalid && m_tready) begin
            if (!mid_frame) begin
                if (exp_order.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame cyc %0d: got data %h, required no frame", cyc, m_tdata);
                    cur_port = 0;
                end else begin
                    cur_port = exp_order.pop_front();
                end
                if (gap_check && have_prev) begin
                    checks++;
                    if (cyc != prev_tlast_cyc + 2) begin
                        errors++;
                        $display("FAIL frame_gap: start cyc %0d, required %0d", cyc, prev_tlast_cyc + 2);
                    end
                end
                if (frames_done == 0) first_start = cyc;
                start_cyc = cyc;
                mid_frame = 1'b1;
                mon_beat  = 0;
            end
            checks++;
            if (m_tdata !== 8'(cur_port*64 + mon_beat)) begin
                errors++;
                $display("FAIL tdata cyc %0d: got %h, required %h", cyc, m_tdata, 8'(cur_port*64 + mon_beat));
            end
            checks++;
            if (m_tlast !== (mon_beat == frame_len - 1)) begin
                errors++;
                $display("FAIL tlast cyc %0d: got %b, required %b", cyc, m_tlast, (mon_beat == frame_len - 1));
            end
            checks++;
            if (m_tuser[0] !== mon_beat[0]) begin
                errors++;
                $display("FAIL tuser cyc %0d: got %b, required %b", cyc, m_tuser[0], mon_beat[0]);
            end
            if (mon_beat == frame_len - 1) begin
                mid_frame      = 1'b0;
                prev_tlast_cyc = cyc;
                have_prev      = 1'b1;
                frames_done++;
                $display("frame %0d: port %0d cycles %0d..%0d", frames_done, cur_port, start_cyc, cyc);
            end else begin
                mon_beat++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) begin
                if (src_beat[i] == frame_len - 1) begin
                    src_beat[i] = 0;
                    src_left[i]--;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic run_until_done(input int n, input int budget, input bit chk_unpaused);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            cycle();
            k++;
            if (chk_unpaused) begin
                checks++;
                if (paused_s !== 1'b0) begin
                    errors++;
                    $display("FAIL paused_disabled cyc %0d: got %b, required 0", cyc, paused_s);
                end
            end
        end
        checks++;
        if (frames_done < n) begin
            errors++;
            $display("FAIL timeout: got %0d frames, required %0d", frames_done, n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_left[i] = 0;
            src_beat[i] = 0;
        end
        exp_order.delete();
        mid_frame = 0; have_prev = 0; frames_done = 0; gap_check = 1;
        m_tready = 1'b1; rx_pause_valid = 1'b0; rx_pause_quanta = '0;
        clk_enable = 1'b1; mii_select = 1'b0; cfg_pause_enable = 1'b1;
        drive_srcs();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        frame_len = 4;
        do_reset();
        rst = 1'b1;
        s_tvalid = 4'hF;
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || s_tready !== 4'b0) begin
            errors++;
            $display("FAIL reset_hold: got gv %b tready %b, required 0 0000", grant_valid, s_tready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_srcs();
        @(negedge clk);
        checks++;
        if (grant_valid !== 1'b0 || grant_index !== 2'd0 || paused !== 1'b0 ||
            s_tready !== 4'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got gv %b gi %0d paused %b tready %b mvalid %b, required 0 0 0 0000 0",
                     grant_valid, grant_index, paused, s_tready, m_tvalid);
        end
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_two_ports();
        int t0;
        frame_len = 60;
        src_left[0] = 1;
        src_left[2] = 1;
        exp_order.push_back(0);
        exp_order.push_back(2);
        drive_srcs();
        t0 = cyc + 1;
        run_until_done(2, 300, 0);
        checks++;
        if (first_start != t0 + 1) begin
            errors++;
            $display("FAIL grant_latency: first beat cyc %0d, required %0d", first_start, t0 + 1);
        end
        $display("test_two_ports done");
    endtask

    task automatic test_round_robin();
        frame_len = 6;
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 4; p++)
                exp_order.push_back(p);
        for (int i = 0; i < 4; i++) src_left[i] = 3;
        drive_srcs();
        run_until_done(12, 200, 0);
        checks++;
        if (exp_order.size() != 0) begin
            errors++;
            $display("FAIL rr_order: %0d frames left, required 0", exp_order.size());
        end
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        int k;
        frame_len = 20;
        do_reset();
        src_left[1] = 1;
        exp_order.push_back(1);
        drive_srcs();
        k = 0;
        while (frames_done < 1 && k < 200) begin
            m_tready = cyc[0];
            cycle();
            k++;
        end
        m_tready = 1'b1;
        checks++;
        if (frames_done != 1) begin
            errors++;
            $display("FAIL backpressure_timeout: got %0d frames, required 1", frames_done);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_gmii_pause();
        int k, cnt, fall_cyc, prev_done;
        frame_len = 20;
        do_reset();
        gap_check = 0;
        src_left[0] = 2;
        exp_order.push_back(0);
        exp_order.push_back(0);
        drive_srcs();
        k = 0;
        while (!(mid_frame && mon_beat == 5) && k < 50) begin
            cycle();
            k++;
        end
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd2;
        cycle();
        rx_pause_valid  = 1'b0;
        cnt = 0;
        fall_cyc = 0;
        for (int j = 0; j < 300; j++) begin
            prev_done = frames_done;
            cycle();
            if (!paused_s) begin
                fall_cyc = cyc;
                break;
            end
            cnt++;
            if (prev_done >= 1) begin
                checks++;
                if (gv_s) begin
                    errors++;
                    $display("FAIL gmii_grant_while_paused cyc %0d: got gv 1, required 0", cyc);
                end
            end
        end
        checks++;
        if (cnt != 128) begin
            errors++;
            $display("FAIL gmii_pause_len: got %0d cycles, required 128", cnt);
        end
        checks++;
        if (frames_done != 1) begin
            errors++;
            $display("FAIL gmii_frame_complete: got %0d frames, required 1", frames_done);
        end
        run_until_done(2, 100, 0);
        checks++;
        if (start_cyc != fall_cyc + 1) begin
            errors++;
            $display("FAIL gmii_resume: start cyc %0d, required %0d", start_cyc, fall_cyc + 1);
        end
        $display("test_gmii_pause done");
    endtask

    task automatic test_mii_pause();
        int cnt, fall_cyc, z;
        frame_len = 4;
        do_reset();
        gap_check = 0;
        mii_select = 1'b1;
        cycle();
        // Request and strobe in the same cycle: grant must be held off
        src_left[3] = 1;
        exp_order.push_back(3);
        drive_srcs();
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd1;
        cycle();
        rx_pause_valid  = 1'b0;
        cnt = 0;
        fall_cyc = 0;
        for (int j = 0; j < 300; j++) begin
            cycle();
            if (!paused_s) begin
                fall_cyc = cyc;
                break;
            end
            cnt++;
            checks++;
            if (gv_s) begin
                errors++;
                $display("FAIL mii_grant_while_paused cyc %0d: got gv 1, required 0", cyc);
            end
        end
        checks++;
        if (cnt != 128) begin
            errors++;
            $display("FAIL mii_pause_len: got %0d cycles, required 128", cnt);
        end
        run_until_done(1, 50, 0);
        checks++;
        if (start_cyc != fall_cyc + 1) begin
            errors++;
            $display("FAIL mii_resume: start cyc %0d, required %0d", start_cyc, fall_cyc + 1);
        end
        // Reload with quanta 0 cancels the pause early
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd1;
        cycle();
        rx_pause_valid  = 1'b0;
        src_left[0] = 1;
        exp_order.push_back(0);
        drive_srcs();
        for (int j = 0; j < 40; j++) begin
            cycle();
            checks++;
            if (paused_s !== 1'b1 || gv_s !== 1'b0) begin
                errors++;
                $display("FAIL mii_hold cyc %0d: got paused %b gv %b, required 1 0", cyc, paused_s, gv_s);
            end
        end
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'd0;
        cycle();
        z = cyc;
        rx_pause_valid  = 1'b0;
        cycle();
        checks++;
        if (paused_s !== 1'b0) begin
            errors++;
            $display("FAIL mii_clear: got paused %b, required 0", paused_s);
        end
        run_until_done(2, 50, 0);
        checks++;
        if (start_cyc != z + 2) begin
            errors++;
            $display("FAIL mii_clear_grant: start cyc %0d, required %0d", start_cyc, z + 2);
        end
        mii_select = 1'b0;
        $display("test_mii_pause done");
    endtask

    task automatic test_pause_disabled();
        frame_len = 8;
        do_reset();
        cfg_pause_enable = 1'b0;
        src_left[1] = 2;
        src_left[2] = 2;
        exp_order.push_back(1);
        exp_order.push_back(2);
        exp_order.push_back(1);
        exp_order.push_back(2);
        drive_srcs();
        for (int j = 0; j < 5; j++) cycle();
        rx_pause_valid  = 1'b1;
        rx_pause_quanta = 16'hFFFF;
        cycle();
        rx_pause_valid  = 1'b0;
        run_until_done(4, 200, 1);
        cfg_pause_enable = 1'b1;
        $display("test_pause_disabled done");
    endtask

    initial begin
        m_tready = 1'b1;
        clk_enable = 1'b1;
        mii_select = 1'b0;
        cfg_pause_enable = 1'b1;
        rx_pause_valid = 1'b0;
        rx_pause_quanta = '0;
        frame_len = 4;
        for (int i = 0; i < 4; i++) begin
            src_left[i] = 0;
            src_beat[i] = 0;
        end
        drive_srcs();
        test_reset();
        test_two_ports();
        test_round_robin();
        test_backpressure();
        test_gmii_pause();
        test_mii_pause();
        test_pause_disabled();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
